// File: rtl/fp_arb_pkg.sv
// Shared types and constants for the two-requester FP add/sub arbiter.
package fp_arb_pkg;

    localparam int DATA_W  = 32;
    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic [0:0] req_id_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way grant selector: a lone request always wins, and simultaneous
// requests are resolved by the pointer.
module rr_arbiter_2
    import fp_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  req_id_t            pointer,
    output logic [NUM_REQ-1:0] grant
);

    // One-hot grant; the pointer matters only when both requesters are pending
    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (pointer == 1'b1) ? 2'b10 : 2'b01;
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/fp_addsub_arbiter.sv
// Shares one FP adder/subtractor between two requesters, one operation in
// flight at a time (IDLE -> BUSY -> RESP). Responses are held until the
// owning requester consumes them.
// Build option: FP_ARB_STRICT_PRIO_EN makes requester 0 win every tie and
// removes the round-robin pointer.
module fp_addsub_arbiter
    import fp_arb_pkg::*;
#(
    parameter int LAT = 1
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req1_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_cout,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_cout,
    output logic [DATA_W-1:0] unit_reg1,
    output logic [DATA_W-1:0] unit_reg2,
    output logic              unit_op,
    input  logic [DATA_W-1:0] unit_result,
    input  logic              unit_cout
);

    localparam logic [3:0] LAT_LD = 4'(LAT);

    state_t              state_q;
    logic [3:0]          cnt_q;
    req_id_t             gid_q;
    logic [DATA_W-1:0]   rsp_result_q;
    logic                rsp_cout_q;
    logic [NUM_REQ-1:0]  grant;
    req_id_t             ptr;
    logic                accept;
    logic                rsp_rdy_sel;
    logic                done;

    rr_arbiter_2 u_arb (
        .req     ({req1_valid, req0_valid}),
        .pointer (ptr),
        .grant   (grant)
    );

    // Ready is offered only in IDLE and is forced low while reset is held
    assign req0_ready  = rst_n && (state_q == IDLE) && grant[0];
    assign req1_ready  = rst_n && (state_q == IDLE) && grant[1];
    assign accept      = req0_ready || req1_ready;

    assign rsp_rdy_sel = (gid_q == 1'b1) ? rsp1_ready : rsp0_ready;
    assign done        = (state_q == RESP) && rsp_rdy_sel;

    assign rsp0_valid  = (state_q == RESP) && (gid_q == 1'b0);
    assign rsp1_valid  = (state_q == RESP) && (gid_q == 1'b1);
    assign rsp0_result = rsp_result_q;
    assign rsp1_result = rsp_result_q;
    assign rsp0_cout   = rsp_cout_q;
    assign rsp1_cout   = rsp_cout_q;

`ifdef FP_ARB_STRICT_PRIO_EN
    assign ptr = 1'b0;
`else
    req_id_t ptr_q;

    // Hand priority to the other requester after every completed response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else if (done) begin
            ptr_q <= ~ptr_q;
        end
    end

    assign ptr = ptr_q;
`endif

    // Operation sequencer: issue operands, wait LAT cycles, hold the response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            gid_q        <= 1'b0;
            unit_reg1    <= '0;
            unit_reg2    <= '0;
            unit_op      <= 1'b0;
            rsp_result_q <= '0;
            rsp_cout_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        unit_reg1 <= grant[1] ? req1_a  : req0_a;
                        unit_reg2 <= grant[1] ? req1_b  : req0_b;
                        unit_op   <= grant[1] ? req1_op : req0_op;
                        gid_q     <= grant[1];
                        cnt_q     <= LAT_LD;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q == 4'd1) begin
                        rsp_result_q <= unit_result;
                        rsp_cout_q   <= unit_cout;
                        cnt_q        <= '0;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_rdy_sel) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Randomized self-checking bench for fp_addsub_arbiter with a transaction
// level arbitration model and a shared-unit model that only presents a
// valid result exactly LAT cycles after an operation is issued.
module tb_fp_addsub_arbiter;

    localparam int LAT = 4;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_op, req1_op;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_result, rsp1_result;
    logic        rsp0_cout, rsp1_cout;
    logic [31:0] unit_reg1, unit_reg2;
    logic        unit_op;
    logic [31:0] unit_result;
    logic        unit_cout;

    int n_vec = 0;
    int n_err = 0;
    int age;
    logic mptr;

    fp_addsub_arbiter #(.LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_cout(rsp0_cout),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_cout(rsp1_cout),
        .unit_reg1(unit_reg1), .unit_reg2(unit_reg2), .unit_op(unit_op),
        .unit_result(unit_result), .unit_cout(unit_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared unit behaviour: known FP vectors from a table, otherwise a
    // plain integer add/sub with carry out
    function automatic logic [32:0] unit_fn(input logic [31:0] a, input logic [31:0] b,
                                            input logic op);
        if (a == 32'h41F0_0000 && b == 32'h4120_0000 && !op) return {1'b0, 32'h4220_0000};
        if (a == 32'h40A0_0000 && b == 32'h4120_0000 &&  op) return {1'b0, 32'hC0A0_0000};
        if (op) return {1'b0, a} - {1'b0, b};
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Cycles since the last issue; the unit output is only meaningful at LAT-1
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                                  age <= 100;
        else if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) age <= 0;
        else if (age < 100)                                          age <= age + 1;
    end

    always_comb begin
        {unit_cout, unit_result} = {1'b1, 32'hBAD0_BAD0};
        if (age == LAT - 1) {unit_cout, unit_result} = unit_fn(unit_reg1, unit_reg2, unit_op);
    end

    task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One complete transaction, starting at a negedge with inputs already driven
    task automatic run_one(input int hold);
        logic        g;
        logic [31:0] ea, eb;
        logic        eop;
        logic [32:0] er;
`ifdef FP_ARB_STRICT_PRIO_EN
        g = (req0_valid && req1_valid) ? 1'b0 : req1_valid;
`else
        g = (req0_valid && req1_valid) ? mptr : req1_valid;
`endif
        ea  = g ? req1_a  : req0_a;
        eb  = g ? req1_b  : req0_b;
        eop = g ? req1_op : req0_op;
        er  = unit_fn(ea, eb, eop);
        #1;
        chk("req0_ready", 33'(req0_ready), 33'(!g));
        chk("req1_ready", 33'(req1_ready), 33'(g));
        step();
        if (g) req1_valid = 1'b0; else req0_valid = 1'b0;
        chk("unit_reg1", 33'(unit_reg1), 33'(ea));
        chk("unit_reg2", 33'(unit_reg2), 33'(eb));
        chk("unit_op", 33'(unit_op), 33'(eop));
        for (int k = 0; k < LAT; k++) begin
            chk("busy_rsp_valid", 33'({rsp1_valid, rsp0_valid}), 33'(0));
            step();
        end
        for (int h = 0; h <= hold; h++) begin
            if (g) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
            #1;
            chk("rsp_valid", 33'({rsp1_valid, rsp0_valid}), g ? 33'(2) : 33'(1));
            chk("rsp_result", g ? {rsp1_cout, rsp1_result} : {rsp0_cout, rsp0_result}, er);
            chk("resp_no_accept", 33'({req1_ready, req0_ready}), 33'(0));
            if (h < hold) step();
        end
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        if (g) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        #1;
        chk("done_no_accept", 33'({req1_ready, req0_ready}), 33'(0));
        step();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        chk("rsp_cleared", 33'({rsp1_valid, rsp0_valid}), 33'(0));
        mptr = ~mptr;
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0; req0_op = 0; req1_op = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        rsp0_ready = 0; rsp1_ready = 0;
        mptr = 1'b0;
        #12;
        chk("rst_unit", {unit_op, unit_reg1}, 33'(0));
        chk("rst_unit2", 33'(unit_reg2), 33'(0));
        chk("rst_rsp", 33'({rsp1_valid, rsp0_valid}), 33'(0));
        chk("rst_rsp_data", {rsp0_cout, rsp0_result}, 33'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Req0 only, FP add vector
        req0_valid = 1; req0_a = 32'h41F0_0000; req0_b = 32'h4120_0000; req0_op = 0;
        run_one(0);

        // Reset asserted mid-BUSY discards the operation
        req0_valid = 1; req0_a = 32'h1234_5678; req0_b = 32'h0101_0101; req0_op = 1;
        #1;
        step();
        req0_valid = 0;
        step();
        req1_valid = 1; req1_a = 32'hAAAA_0000; req1_b = 32'h0000_5555;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_unit", {unit_op, unit_reg1}, 33'(0));
        chk("mid_rst_unit2", 33'(unit_reg2), 33'(0));
        chk("mid_rst_ready", 33'({req1_ready, req0_ready}), 33'(0));
        chk("mid_rst_rsp", 33'({rsp1_valid, rsp0_valid}), 33'(0));
        chk("mid_rst_data", {rsp0_cout, rsp0_result}, 33'(0));
        @(negedge clk);
        req1_valid = 0;
        rst_n = 1'b1;
        mptr = 1'b0;
        for (int k = 0; k < LAT + 4; k++) begin
            #1;
            chk("post_rst_rsp", 33'({rsp1_valid, rsp0_valid}), 33'(0));
            step();
        end

        // Both valid repeatedly
        for (int i = 0; i < 4; i++) begin
            if (!req0_valid) begin req0_valid = 1; req0_a = $urandom; req0_b = $urandom; req0_op = 1'($urandom); end
            if (!req1_valid) begin req1_valid = 1; req1_a = $urandom; req1_b = $urandom; req1_op = 1'($urandom); end
            run_one(0);
        end
        run_one(1);

        // Req1 subtract vector
        req1_valid = 1; req1_a = 32'h40A0_0000; req1_b = 32'h4120_0000; req1_op = 1;
        run_one(0);

        // Long response stall with a competing request pending
        req0_valid = 1; req0_a = $urandom; req0_b = $urandom; req0_op = 0;
        req1_valid = 1; req1_a = $urandom; req1_b = $urandom; req1_op = 1;
        run_one(5);
        run_one(0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            if (!req0_valid && ($urandom_range(0, 1) == 1)) begin
                req0_valid = 1; req0_a = $urandom; req0_b = $urandom; req0_op = 1'($urandom);
            end
            if (!req1_valid && ($urandom_range(0, 1) == 1)) begin
                req1_valid = 1; req1_a = $urandom; req1_b = $urandom; req1_op = 1'($urandom);
            end
            if (!req0_valid && !req1_valid) begin
                req0_valid = 1; req0_a = $urandom; req0_b = $urandom; req0_op = 1'($urandom);
            end
            run_one($urandom_range(0, 3));
        end
        while (req0_valid || req1_valid) run_one(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
